// File: rtl/aes_pkg.sv
// ============================================================================
// aes_pkg : shared constants, state encoding and GF(2^8) helpers for the
//           AES-128 decryption sequencing controller
// Rev 1.0
// ============================================================================
`default_nettype none

package aes_pkg;

    localparam int RK_W       = 128;
    localparam int NUM_ROUNDS = 10;
    localparam int NUM_RK     = NUM_ROUNDS + 1;

    // Element i is the round constant used to derive rk[i]
    localparam logic [NUM_ROUNDS:1][7:0] RCON = {
        8'h36, 8'h1b, 8'h80, 8'h40, 8'h20,
        8'h10, 8'h08, 8'h04, 8'h02, 8'h01
    };

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_EXPAND = 3'd1,
        S_ISSUE  = 3'd2,
        S_WAIT   = 3'd3,
        S_HOLD   = 3'd4
    } state_t;

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // a^254 is the multiplicative inverse in GF(2^8); maps 0 to 0 as the S-box needs
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] sq;
        logic [7:0] acc;
        sq  = a;
        acc = 8'h01;
        for (int i = 1; i < 8; i++) begin
            sq  = gf_mul(sq, sq);
            acc = gf_mul(acc, sq);
        end
        return acc;
    endfunction

endpackage

`default_nettype wire

// File: rtl/aes_dec_sched_ctrl_if.sv
// ============================================================================
// aes_dec_sched_ctrl_if : key, ciphertext/plaintext streams and core bus
// Rev 1.0
// ============================================================================
`default_nettype none

interface aes_dec_sched_ctrl_if;
    import aes_pkg::*;

    logic                     key_load;
    logic [RK_W-1:0]          key_in;
    logic                     key_ready;
    logic                     keys_valid;

    logic                     s_valid;
    logic                     s_ready;
    logic [127:0]             s_data;

    logic                     m_valid;
    logic                     m_ready;
    logic [127:0]             m_data;

    logic                     core_start;
    logic [127:0]             core_ciphertext;
    logic [NUM_RK*RK_W-1:0]   core_rk;
    logic                     core_valid;
    logic [127:0]             core_plaintext;

    logic                     timeout_err;

    // Environment side: key source, stream endpoints and the decryption core
    modport master (
        output key_load, key_in, s_valid, s_data, m_ready, core_valid, core_plaintext,
        input  key_ready, keys_valid, s_ready, m_valid, m_data,
               core_start, core_ciphertext, core_rk, timeout_err
    );

    // Controller side
    modport slave (
        input  key_load, key_in, s_valid, s_data, m_ready, core_valid, core_plaintext,
        output key_ready, keys_valid, s_ready, m_valid, m_data,
               core_start, core_ciphertext, core_rk, timeout_err
    );

endinterface

`default_nettype wire

// File: rtl/aes_key_step.sv
// ============================================================================
// aes_key_step : one AES-128 key-expansion round, rk[i-1] -> rk[i]
// Rev 1.0
// ============================================================================
`default_nettype none

module aes_key_step
    import aes_pkg::*;
(
    input  logic [RK_W-1:0] prev_key,
    input  logic [7:0]      rcon,
    output logic [RK_W-1:0] next_key
);

    logic [31:0] w_w0, w_w1, w_w2, w_w3;
    logic [31:0] w_rot, w_sub, w_temp;
    logic [31:0] w_n0, w_n1, w_n2, w_n3;

    // Word 0 is the most significant word, matching byte 0 at [127:120]
    assign w_w0 = prev_key[127:96];
    assign w_w1 = prev_key[95:64];
    assign w_w2 = prev_key[63:32];
    assign w_w3 = prev_key[31:0];

    assign w_rot = {w_w3[23:0], w_w3[31:24]};

    for (genvar g = 0; g < 4; g++) begin : g_sbox
        aes_sbox u_sbox (
            .x (w_rot[8*g +: 8]),
            .y (w_sub[8*g +: 8])
        );
    end

    assign w_temp = w_sub ^ {rcon, 24'h000000};

    assign w_n0 = w_w0 ^ w_temp;
    assign w_n1 = w_w1 ^ w_n0;
    assign w_n2 = w_w2 ^ w_n1;
    assign w_n3 = w_w3 ^ w_n2;

    assign next_key = {w_n0, w_n1, w_n2, w_n3};

endmodule

`default_nettype wire

// File: rtl/aes_sbox.sv
// ============================================================================
// aes_sbox : forward AES S-box, GF(2^8) inverse followed by the affine map
// Rev 1.0
// ============================================================================
`default_nettype none

module aes_sbox
    import aes_pkg::*;
(
    input  logic [7:0] x,
    output logic [7:0] y
);

    logic [7:0] w_inv;

    assign w_inv = gf_inv(x);

    assign y = w_inv
             ^ {w_inv[6:0], w_inv[7]}
             ^ {w_inv[5:0], w_inv[7:6]}
             ^ {w_inv[4:0], w_inv[7:5]}
             ^ {w_inv[3:0], w_inv[7:4]}
             ^ 8'h63;

endmodule

`default_nettype wire

// File: rtl/aes_dec_sched_ctrl.sv
// ============================================================================
// aes_dec_sched_ctrl : round-key expansion, block issue, watchdog and output
//                      buffering around an iterative AES-128 decryption core
// Rev 1.0
// ============================================================================
`default_nettype none

module aes_dec_sched_ctrl
    import aes_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 32
)
(
    input  logic                 clk,
    input  logic                 rst_n,
    aes_dec_sched_ctrl_if.slave  bus
);

    localparam int          WD_W   = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WD_W-1:0] WD_MAX = {WD_W{1'b1}};
    localparam logic [WD_W-1:0] WD_TO  = WD_W'(TIMEOUT_CYCLES);
    localparam logic [3:0]  LAST_RND = 4'(NUM_ROUNDS);

    state_t                      r_state;
    state_t                      w_next_state;

    logic [NUM_RK-1:0][RK_W-1:0] r_rk;
    logic [3:0]                  r_round;
    logic [WD_W-1:0]             r_wd;
    logic                        r_keys_valid;
    logic                        r_timeout;
    logic [127:0]                r_ct;
    logic                        r_m_valid;
    logic [127:0]                r_m_data;

    logic [WD_W-1:0]             w_wd_inc;
    logic [RK_W-1:0]             w_prev_key;
    logic [RK_W-1:0]             w_next_key;
    logic [7:0]                  w_rcon;
    logic                        w_key_ready;
    logic                        w_s_ready;
    logic                        w_core_start;
    logic                        w_key_go;
    logic                        w_accept;
    logic                        w_capture;
    logic                        w_timeout;
    logic                        w_release;

    assign w_wd_inc = (r_wd == WD_MAX) ? r_wd : r_wd + 1'b1;

    // Select the previous round key and its round constant by round number
    always_comb begin
        w_prev_key = '0;
        w_rcon     = 8'h00;
        for (int i = 1; i < NUM_RK; i++) begin
            if (r_round == 4'(i)) begin
                w_prev_key = r_rk[i-1];
                w_rcon     = RCON[i];
            end
        end
    end

    aes_key_step u_key_step (
        .prev_key (w_prev_key),
        .rcon     (w_rcon),
        .next_key (w_next_key)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        w_key_ready  = 1'b0;
        w_s_ready    = 1'b0;
        w_core_start = 1'b0;
        w_key_go     = 1'b0;
        w_accept     = 1'b0;
        w_capture    = 1'b0;
        w_timeout    = 1'b0;
        w_release    = 1'b0;
        case (r_state)
            S_IDLE: begin
                // rst_n keeps key_ready low while reset is held
                w_key_ready = rst_n;
                w_s_ready   = r_keys_valid & ~bus.key_load;
                if (bus.key_load) begin
                    w_key_go     = 1'b1;
                    w_next_state = S_EXPAND;
                end else if (bus.s_valid && w_s_ready) begin
                    w_accept     = 1'b1;
                    w_next_state = S_ISSUE;
                end
            end
            S_EXPAND: begin
                if (r_round == LAST_RND) w_next_state = S_IDLE;
            end
            S_ISSUE: begin
                w_core_start = 1'b1;
                w_next_state = S_WAIT;
            end
            S_WAIT: begin
                if (bus.core_valid) begin
                    w_capture    = 1'b1;
                    w_next_state = S_HOLD;
                end else if (w_wd_inc == WD_TO) begin
                    w_timeout    = 1'b1;
                    w_next_state = S_IDLE;
                end
            end
            S_HOLD: begin
                if (bus.m_ready) begin
                    w_release    = 1'b1;
                    w_next_state = S_IDLE;
                end
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    // Round keys: rk0 on load, then one round key per expansion cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rk         <= '0;
            r_round      <= 4'd0;
            r_keys_valid <= 1'b0;
        end else if (w_key_go) begin
            r_rk[0]      <= bus.key_in;
            r_round      <= 4'd1;
            r_keys_valid <= 1'b0;
        end else if (r_state == S_EXPAND) begin
            for (int i = 1; i < NUM_RK; i++) begin
                if (r_round == 4'(i)) r_rk[i] <= w_next_key;
            end
            r_round <= r_round + 4'd1;
            if (r_round == LAST_RND) r_keys_valid <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wd      <= '0;
            r_timeout <= 1'b0;
        end else begin
            if (r_state == S_ISSUE)     r_wd <= '0;
            else if (r_state == S_WAIT) r_wd <= w_wd_inc;

            if (w_key_go)       r_timeout <= 1'b0;
            else if (w_timeout) r_timeout <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ct      <= '0;
            r_m_valid <= 1'b0;
            r_m_data  <= '0;
        end else begin
            if (w_accept) r_ct <= bus.s_data;

            if (w_capture) begin
                r_m_data  <= bus.core_plaintext;
                r_m_valid <= 1'b1;
            end else if (w_release) begin
                r_m_valid <= 1'b0;
            end
        end
    end

    assign bus.key_ready       = w_key_ready;
    assign bus.keys_valid      = r_keys_valid;
    assign bus.s_ready         = w_s_ready;
    assign bus.m_valid         = r_m_valid;
    assign bus.m_data          = r_m_data;
    assign bus.core_start      = w_core_start;
    assign bus.core_ciphertext = r_ct;
    assign bus.core_rk         = r_rk;
    assign bus.timeout_err     = r_timeout;

endmodule

`default_nettype wire

// File: tb/tb_aes_dec_sched_ctrl.sv
// ============================================================================
// tb_aes_dec_sched_ctrl : vector table plus scoreboard bench with a
//                         behavioural fixed-latency decryption core
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_aes_dec_sched_ctrl;
    import aes_pkg::*;

    localparam int TIMEOUT = 32;
    localparam int LAT     = 13;
    localparam logic [127:0] KEY      = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] RK1_EXP  = 128'hd6aa74fdd2af72fadaa678f1d6ab76fe;
    localparam logic [127:0] RK10_EXP = 128'h13111d7fe3944a17f307a78b4d2b30c5;
    localparam logic [127:0] FIPS_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] FIPS_PT  = 128'h00112233445566778899aabbccddeeff;

    typedef struct {
        logic [127:0] ct;
        logic [127:0] exp;
        int           stall;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    aes_dec_sched_ctrl_if bus();

    aes_dec_sched_ctrl #(.TIMEOUT_CYCLES(TIMEOUT)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;
    logic [127:0] sb_q[$];
    int stall_req = 0;
    bit core_en = 1'b1;
    int start_cnt = 0;
    vec_t vecs[4];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Known-answer result for the reference block; otherwise a key-dependent stand-in
    function automatic logic [127:0] core_model(input logic [127:0] ct, input logic [NUM_RK*RK_W-1:0] rk);
        if (ct == FIPS_CT && rk[127:0] == KEY && rk[1407:1280] == RK10_EXP)
            return FIPS_PT;
        return ct ^ rk[127:0] ^ rk[1407:1280];
    endfunction

    initial begin
        int cnt;
        bit pend;
        logic [127:0] ct;
        cnt = 0;
        pend = 1'b0;
        ct = '0;
        bus.core_valid = 1'b0;
        bus.core_plaintext = '0;
        forever begin
            @(negedge clk);
            bus.core_valid = 1'b0;
            if (!rst_n) begin
                pend = 1'b0;
            end else begin
                if (pend) begin
                    cnt--;
                    if (cnt == 0) begin
                        pend = 1'b0;
                        bus.core_valid = 1'b1;
                        bus.core_plaintext = core_model(ct, bus.core_rk);
                    end
                end
                if (bus.core_start) begin
                    start_cnt++;
                    if (core_en) begin
                        pend = 1'b1;
                        cnt = LAT;
                        ct = bus.core_ciphertext;
                    end
                end
            end
        end
    end

    initial begin
        bit holding;
        bit released;
        int stall;
        logic [127:0] held;
        logic [127:0] exp;
        holding = 1'b0;
        released = 1'b0;
        stall = 0;
        held = '0;
        bus.m_ready = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                bus.m_ready = 1'b0;
                holding = 1'b0;
                released = 1'b0;
            end else begin
                if (released) begin
                    #1;
                    check("s_ready_after_release", bus.s_ready, 1);
                    released = 1'b0;
                end
                if (bus.m_valid) begin
                    if (!holding) begin
                        holding = 1'b1;
                        held = bus.m_data;
                        stall = stall_req;
                    end else begin
                        check("m_data_stable", bus.m_data, held);
                    end
                    if (stall > 0) begin
                        stall--;
                        bus.m_ready = 1'b0;
                        #1;
                        check("s_ready_in_hold", bus.s_ready, 0);
                    end else begin
                        bus.m_ready = 1'b1;
                        if (sb_q.size() == 0) begin
                            check("unexpected_output", 1, 0);
                        end else begin
                            exp = sb_q.pop_front();
                            check("m_data", bus.m_data, exp);
                        end
                        released = 1'b1;
                        holding = 1'b0;
                    end
                end else begin
                    bus.m_ready = 1'b0;
                end
            end
        end
    end

    task automatic load_key(input logic [127:0] k);
        bus.key_in = k;
        bus.key_load = 1'b1;
        #1;
        check("key_ready_idle", bus.key_ready, 1);
        check("s_ready_on_key_load", bus.s_ready, 0);
        @(negedge clk);
        bus.key_load = 1'b0;
        for (int c = 1; c <= 11; c++) begin
            if (c == 1) begin
                check("keys_valid_cleared", bus.keys_valid, 0);
                check("key_ready_expand", bus.key_ready, 0);
                check("timeout_err_cleared", bus.timeout_err, 0);
            end
            if (c <= 10) check("s_ready_expand", bus.s_ready, 0);
            if (c == 10) begin
                check("keys_valid_c10", bus.keys_valid, 0);
                bus.s_valid = 1'b0;
            end
            if (c == 11) check("keys_valid_c11", bus.keys_valid, 1);
            if (c < 11) @(negedge clk);
        end
    endtask

    task automatic check_keys();
        check("rk0", bus.core_rk[127:0], KEY);
        check("rk1", bus.core_rk[255:128], RK1_EXP);
        check("rk10", bus.core_rk[1407:1280], RK10_EXP);
    endtask

    task automatic send_block(input logic [127:0] ct, input logic [127:0] exp, input bit expect_out);
        bit acc;
        if (expect_out) sb_q.push_back(exp);
        bus.s_data = ct;
        bus.s_valid = 1'b1;
        acc = 1'b0;
        for (int n = 0; n < 200 && !acc; n++) begin
            #1;
            if (bus.s_ready) acc = 1'b1;
            @(negedge clk);
        end
        bus.s_valid = 1'b0;
        check("block_accepted", acc, 1);
    endtask

    task automatic wait_idle();
        bit done;
        done = 1'b0;
        for (int n = 0; n < 300 && !done; n++) begin
            @(negedge clk);
            if (sb_q.size() == 0 && !bus.m_valid) done = 1'b1;
        end
        check("output_within_budget", done, 1);
        repeat (2) @(negedge clk);
    endtask

    initial begin
        int s0;
        vecs[0] = '{ct: FIPS_CT, exp: FIPS_PT, stall: 0};
        vecs[1] = '{ct: 128'hdeadbeef_01234567_89abcdef_0f1e2d3c,
                    exp: 128'hdeadbeef_01234567_89abcdef_0f1e2d3c ^ KEY ^ RK10_EXP, stall: 0};
        vecs[2] = '{ct: 128'hffffffff_ffffffff_00000000_00000000,
                    exp: 128'hffffffff_ffffffff_00000000_00000000 ^ KEY ^ RK10_EXP, stall: 3};
        vecs[3] = '{ct: 128'h5a5a5a5a_a5a5a5a5_3c3c3c3c_c3c3c3c3,
                    exp: 128'h5a5a5a5a_a5a5a5a5_3c3c3c3c_c3c3c3c3 ^ KEY ^ RK10_EXP, stall: 20};

        bus.key_load = 1'b0;
        bus.key_in = '0;
        bus.s_valid = 1'b0;
        bus.s_data = '0;

        repeat (3) @(negedge clk);
        #1;
        check("rst_key_ready", bus.key_ready, 0);
        check("rst_keys_valid", bus.keys_valid, 0);
        check("rst_s_ready", bus.s_ready, 0);
        check("rst_m_valid", bus.m_valid, 0);
        check("rst_m_data", bus.m_data, 0);
        check("rst_core_start", bus.core_start, 0);
        check("rst_timeout_err", bus.timeout_err, 0);
        check("rst_rk_lo", bus.core_rk[127:0], 0);
        check("rst_rk_hi", bus.core_rk[1407:1280], 0);
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_key_ready", bus.key_ready, 1);

        // Blocks offered before any key set must be refused
        s0 = start_cnt;
        bus.s_valid = 1'b1;
        bus.s_data = FIPS_CT;
        repeat (5) begin
            #1;
            check("s_ready_no_keys", bus.s_ready, 0);
            @(negedge clk);
        end
        bus.s_valid = 1'b0;
        check("no_start_without_keys", start_cnt, s0);

        load_key(KEY);
        check_keys();

        for (int v = 0; v < 4; v++) begin
            stall_req = vecs[v].stall;
            s0 = start_cnt;
            send_block(vecs[v].ct, vecs[v].exp, 1'b1);
            wait_idle();
            check("one_core_start", start_cnt, s0 + 1);
        end
        stall_req = 0;

        // key_load and s_valid together: the key wins and the block is dropped
        s0 = start_cnt;
        bus.s_data = vecs[1].ct;
        bus.s_valid = 1'b1;
        load_key(KEY);
        check("priority_no_start", start_cnt, s0);
        check_keys();
        send_block(vecs[1].ct, vecs[1].exp, 1'b1);
        wait_idle();

        // Watchdog: the core never answers
        core_en = 1'b0;
        s0 = start_cnt;
        send_block(vecs[2].ct, '0, 1'b0);
        check("wd_core_start", bus.core_start, 1);
        for (int j = 1; j <= 33; j++) begin
            @(negedge clk);
            if (j == 32) check("timeout_err_c32", bus.timeout_err, 0);
            if (j == 33) begin
                check("timeout_err_c33", bus.timeout_err, 1);
                check("wd_no_output", bus.m_valid, 0);
                #1;
                check("wd_back_idle", bus.s_ready, 1);
            end
        end
        core_en = 1'b1;
        check("wd_single_start", start_cnt, s0 + 1);
        load_key(KEY);

        // Reset while the core is busy
        send_block(FIPS_CT, FIPS_PT, 1'b1);
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        #1;
        sb_q.delete();
        check("mid_rst_keys_valid", bus.keys_valid, 0);
        check("mid_rst_m_valid", bus.m_valid, 0);
        check("mid_rst_m_data", bus.m_data, 0);
        check("mid_rst_core_ct", bus.core_ciphertext, 0);
        check("mid_rst_rk10", bus.core_rk[1407:1280], 0);
        check("mid_rst_s_ready", bus.s_ready, 0);
        check("mid_rst_key_ready", bus.key_ready, 0);
        check("mid_rst_core_start", bus.core_start, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        load_key(KEY);
        check_keys();
        send_block(FIPS_CT, FIPS_PT, 1'b1);
        wait_idle();
        check("scoreboard_drained", sb_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
